// File: rtl/sim_stim_driver_pkg.sv
// Shared types and helpers for the stimulus driver: FSM state encoding and a
// saturating counter increment usable for any counter width up to 32 bits.
package sim_stim_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Returns v+1, holding at 2^w-1 once the counter is full.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= max_v) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/sim_stim_driver_if.sv
// Stimulus/response bundle between the driver (master) and its controller and
// the block under test (slave side).
interface sim_stim_driver_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    import sim_stim_driver_pkg::*;

    logic             start;
    logic [CNT_W-1:0] num_events;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] i_out;
    logic [WIDTH-1:0] y_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ev_count;
    logic [CNT_W-1:0] resp_count;

    modport master (
        input  start, num_events, step, y_in,
        output i_out, busy, done, ev_count, resp_count
    );

    modport slave (
        output start, num_events, step, y_in,
        input  i_out, busy, done, ev_count, resp_count
    );

endinterface

// File: rtl/sim_stim_driver_change_detect.sv
// Registers the response bus every cycle and flags any cycle in which it
// differs from the previous sample. Ungated; the parent decides when to count.
module change_detect
    import sim_stim_driver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] y_i,
    output logic             chg_o
);

    logic [WIDTH-1:0] y_prev_q;
    logic [WIDTH-1:0] y_prev_d;

    assign y_prev_d = y_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_prev_q <= '0;
        end else begin
            y_prev_q <= y_prev_d;
        end
    end

    assign chg_o = (y_i != y_prev_q);

endmodule

// File: rtl/sim_stim_driver.sv
// Burst stimulus source: steps i_out a programmed number of times with a settle
// window between steps, and counts response-bus changes while a burst is live.
module sim_stim_driver
    import sim_stim_driver_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sim_stim_driver_if.master   bus_io
);

    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] iout_q, iout_d;
    logic [CNT_W-1:0] ev_q, ev_d;
    logic [CNT_W-1:0] resp_q, resp_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             busy;
    logic             chg;

    change_detect #(
        .WIDTH (WIDTH)
    ) u_change_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .y_i   (bus_io.y_in),
        .chg_o (chg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The settle counter is loaded with SETTLE_CYC in DRIVE, so the burst
    // spends exactly SETTLE_CYC cycles in SETTLE and expires at a count of 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    state_d = (bus_io.num_events == '0) ? DONE : DRIVE;
                end
            end
            DRIVE:  state_d = SETTLE;
            SETTLE: begin
                if (settle_q == SET_W'(1)) begin
                    state_d = (ev_q == num_q) ? DONE : DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        bus_io.busy       = busy;
        bus_io.done       = (state_q == DONE);
        bus_io.i_out      = iout_q;
        bus_io.ev_count   = ev_q;
        bus_io.resp_count = resp_q;
    end

    always_comb begin
        num_d    = num_q;
        step_d   = step_q;
        iout_d   = iout_q;
        ev_d     = ev_q;
        resp_d   = resp_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    num_d  = bus_io.num_events;
                    step_d = bus_io.step;
                    ev_d   = '0;
                    resp_d = '0;
                end
            end
            DRIVE: begin
                iout_d   = iout_q + step_q;
                ev_d     = ev_q + CNT_W'(1);
                settle_d = SET_W'(SETTLE_CYC);
            end
            SETTLE:  settle_d = settle_q - SET_W'(1);
            default: ;
        endcase
        // Monitoring is live from the first busy cycle through DONE; the IDLE
        // clear above never overlaps with it.
        if (busy && chg) begin
            resp_d = CNT_W'(sat_inc(32'(resp_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q    <= '0;
            step_q   <= '0;
            iout_q   <= '0;
            ev_q     <= '0;
            resp_q   <= '0;
            settle_q <= '0;
        end else begin
            num_q    <= num_d;
            step_q   <= step_d;
            iout_q   <= iout_d;
            ev_q     <= ev_d;
            resp_q   <= resp_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: tb/tb_sim_stim_driver.sv
// Directed bench for sim_stim_driver: a cycle table for the first burst plus
// hand-written sequences for zero-length, wrap, ignored start, reset and saturation.
module tb_sim_stim_driver;

    logic clk;
    logic rst_n;
    logic track;
    logic tog;
    int   n_cmp;
    int   n_bad;

    sim_stim_driver_if #(.WIDTH(4), .CNT_W(8)) b1 ();
    sim_stim_driver_if #(.WIDTH(4), .CNT_W(4)) b2 ();

    sim_stim_driver #(.WIDTH(4), .CNT_W(8), .SETTLE_CYC(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (b1)
    );

    sim_stim_driver #(.WIDTH(4), .CNT_W(4), .SETTLE_CYC(2)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response of a one-register block under test, or a frozen bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b1.y_in <= 4'h0;
        end else if (track) begin
            b1.y_in <= b1.i_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b2.y_in <= 4'h0;
        end else if (tog) begin
            b2.y_in <= ~b2.y_in;
        end
    end

    typedef struct {
        logic [3:0] iout;
        logic       busy;
        logic       done;
        logic [7:0] ev;
    } row_t;

    row_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input logic [7:0] n, input logic [3:0] s, output int cyc);
        b1.num_events = n;
        b1.step       = s;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        cyc = 1;
        while (b1.done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{4'd0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{4'd1, 1'b1, 1'b0, 8'd1};
        tbl[2]  = '{4'd1, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{4'd1, 1'b1, 1'b0, 8'd1};
        tbl[4]  = '{4'd2, 1'b1, 1'b0, 8'd2};
        tbl[5]  = '{4'd2, 1'b1, 1'b0, 8'd2};
        tbl[6]  = '{4'd2, 1'b1, 1'b0, 8'd2};
        tbl[7]  = '{4'd3, 1'b1, 1'b0, 8'd3};
        tbl[8]  = '{4'd3, 1'b1, 1'b0, 8'd3};
        tbl[9]  = '{4'd3, 1'b1, 1'b1, 8'd3};
        tbl[10] = '{4'd3, 1'b0, 1'b0, 8'd3};

        rst_n = 1'b0;
        track = 1'b1;
        tog   = 1'b0;
        b1.start = 1'b0; b1.num_events = '0; b1.step = '0;
        b2.start = 1'b0; b2.num_events = '0; b2.step = '0;
        tick(); tick(); tick();
        check("reset_iout", 32'(b1.i_out), 0);
        check("reset_busy", 32'(b1.busy), 0);
        check("reset_done", 32'(b1.done), 0);
        check("reset_ev",   32'(b1.ev_count), 0);
        check("reset_resp", 32'(b1.resp_count), 0);
        rst_n = 1'b1;
        tick();

        // N=3, step=1: cycle-by-cycle against the table, starting at t+1.
        b1.num_events = 8'd3;
        b1.step       = 4'd1;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int k = 0; k < 11; k++) begin
            check($sformatf("t1_iout_k%0d", k + 1), 32'(b1.i_out), 32'(tbl[k].iout));
            check($sformatf("t1_busy_k%0d", k + 1), 32'(b1.busy), 32'(tbl[k].busy));
            check($sformatf("t1_done_k%0d", k + 1), 32'(b1.done), 32'(tbl[k].done));
            check($sformatf("t1_ev_k%0d", k + 1), 32'(b1.ev_count), 32'(tbl[k].ev));
            if (tbl[k].done) check("t1_resp_at_done", 32'(b1.resp_count), 3);
            if (k < 10) tick();
        end
        check("t1_resp_after", 32'(b1.resp_count), 3);

        // N=0: immediate DONE, i_out untouched.
        b1.num_events = 8'd0;
        b1.step       = 4'd5;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        check("n0_done", 32'(b1.done), 1);
        check("n0_busy", 32'(b1.busy), 1);
        check("n0_ev",   32'(b1.ev_count), 0);
        check("n0_resp", 32'(b1.resp_count), 0);
        check("n0_iout", 32'(b1.i_out), 3);
        tick();
        check("n0_busy_fall", 32'(b1.busy), 0);

        // step=0, N=4, frozen response.
        track = 1'b0;
        run_burst(8'd4, 4'd0, c);
        check("s0_done_cyc", 32'(c), 13);
        check("s0_ev",   32'(b1.ev_count), 4);
        check("s0_resp", 32'(b1.resp_count), 0);
        check("s0_iout", 32'(b1.i_out), 3);
        tick();

        // Move to 0xE, then wrap with step=3 and try a start while busy.
        run_burst(8'd1, 4'd11, c);
        check("pre_done_cyc", 32'(c), 4);
        check("pre_iout", 32'(b1.i_out), 14);
        tick();
        b1.num_events = 8'd2;
        b1.step       = 4'd3;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        tick();
        check("wrap_iout0", 32'(b1.i_out), 1);
        b1.num_events = 8'd7;
        b1.step       = 4'd5;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        check("busy_start_ev", 32'(b1.ev_count), 1);
        tick(); tick();
        check("wrap_iout1", 32'(b1.i_out), 4);
        tick();
        check("wrap_done_t6", 32'(b1.done), 0);
        tick();
        check("wrap_done_t7", 32'(b1.done), 1);
        check("wrap_ev", 32'(b1.ev_count), 2);
        tick();
        check("wrap_idle_busy", 32'(b1.busy), 0);
        check("wrap_idle_iout", 32'(b1.i_out), 4);

        // Reset in mid-SETTLE with start also asserted: reset wins.
        track = 1'b1;
        b1.num_events = 8'd3;
        b1.step       = 4'd1;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        tick();
        rst_n = 1'b0;
        b1.start = 1'b1;
        b1.num_events = 8'd5;
        tick();
        rst_n = 1'b1;
        b1.start = 1'b0;
        check("rst_iout", 32'(b1.i_out), 0);
        check("rst_busy", 32'(b1.busy), 0);
        check("rst_done", 32'(b1.done), 0);
        check("rst_ev",   32'(b1.ev_count), 0);
        check("rst_resp", 32'(b1.resp_count), 0);
        tick();
        check("rst_still_idle", 32'(b1.busy), 0);
        run_burst(8'd2, 4'd1, c);
        check("post_rst_done_cyc", 32'(c), 7);
        check("post_rst_iout", 32'(b1.i_out), 2);
        check("post_rst_ev",   32'(b1.ev_count), 2);
        check("post_rst_resp", 32'(b1.resp_count), 2);
        tick();

        // 4-bit counters: response toggling every cycle saturates at 15.
        tog = 1'b1;
        b2.num_events = 4'd10;
        b2.step       = 4'd1;
        b2.start      = 1'b1;
        tick();
        b2.start = 1'b0;
        c = 1;
        while (b2.done !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
        check("sat_done_cyc", 32'(c), 31);
        check("sat_ev",   32'(b2.ev_count), 10);
        check("sat_resp", 32'(b2.resp_count), 15);
        check("sat_iout", 32'(b2.i_out), 10);
        tick();
        tog = 1'b0;
        check("sat_resp_hold", 32'(b2.resp_count), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
